// File: rtl/sr_mon_pkg.sv
// +--------------------------------------------------------------------+
// | sr_mon_pkg : shared types and constants for the SR latch monitor   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package sr_mon_pkg;

  typedef enum logic [1:0] {
    ST_UNKNOWN = 2'd0,
    ST_Q0      = 2'd1,
    ST_Q1      = 2'd2,
    ST_FORBID  = 2'd3
  } state_t;

  // A NOR latch with both inputs asserted drives both outputs low.
  localparam logic [1:0] C_FORBID_QQN = 2'b00;

endpackage

`default_nettype wire

// File: rtl/sync2.sv
// +--------------------------------------------------------------------+
// | sync2 : parameterised-width two-flop synchronizer, async reset     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= '0;
      q      <= '0;
    end else begin
      r_meta <= d;
      q      <= r_meta;
    end
  end

endmodule

`default_nettype wire

// File: rtl/sr_latch_monitor.sv
// +--------------------------------------------------------------------+
// | sr_latch_monitor : predicts SR latch state, flags settled output   |
// | mismatches and forbidden inputs, keeps saturating event counters   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module sr_latch_monitor
  import sr_mon_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             S,
  input  logic             R,
  input  logic             Q,
  input  logic             Qn,
  output logic             pred_q,
  output logic             pred_valid,
  output logic             forbidden,
  output logic             mismatch,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] forbid_count
);

  localparam int              SW       = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
  localparam logic [SW-1:0]   C_SETTLE = SW'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

  logic [3:0]    w_sync;
  logic          w_s, w_r, w_q, w_qn;
  logic [1:0]    w_sr;
  logic [1:0]    w_exp;
  logic          w_change;
  logic          w_fail;
  state_t        r_state;
  state_t        w_next;
  logic [1:0]    r_sr_prev;
  logic [SW-1:0] r_settle;
  logic          r_armed;

  sync2 #(.WIDTH(4)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     ({S, R, Q, Qn}),
    .q     (w_sync)
  );

  assign {w_s, w_r, w_q, w_qn} = w_sync;
  assign w_sr     = {w_s, w_r};
  assign w_change = (w_sr != r_sr_prev);

  always_comb begin
    w_next = r_state;
    case (w_sr)
      2'b10:   w_next = ST_Q1;
      2'b01:   w_next = ST_Q0;
      2'b11:   w_next = ST_FORBID;
      default: w_next = (r_state == ST_FORBID) ? ST_UNKNOWN : r_state;
    endcase
  end

  always_comb begin
    w_exp = C_FORBID_QQN;
    if (r_state == ST_Q1)      w_exp = 2'b10;
    else if (r_state == ST_Q0) w_exp = 2'b01;
  end

  assign w_fail = ({w_q, w_qn} != w_exp);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_UNKNOWN;
      pred_q       <= 1'b0;
      pred_valid   <= 1'b0;
      forbidden    <= 1'b0;
      forbid_count <= '0;
    end else begin
      r_state    <= w_next;
      pred_q     <= (w_next == ST_Q1);
      pred_valid <= (w_next == ST_Q0) || (w_next == ST_Q1);
      forbidden  <= (w_next == ST_FORBID);
      if ((w_next == ST_FORBID) && (r_state != ST_FORBID) && (forbid_count != C_CNT_MAX))
        forbid_count <= forbid_count + CNT_W'(1);
    end
  end

  // An input change reloads the settle window and wins over any compare.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr_prev <= 2'b00;
      r_settle  <= '0;
      r_armed   <= 1'b1;
      mismatch  <= 1'b0;
      err_count <= '0;
    end else begin
      r_sr_prev <= w_sr;
      mismatch  <= 1'b0;
      if (w_change) begin
        r_settle <= C_SETTLE;
        r_armed  <= 1'b1;
      end else if (r_settle != '0) begin
        r_settle <= r_settle - SW'(1);
      end else if (r_state != ST_UNKNOWN) begin
        if (w_fail) begin
          if (r_armed) begin
            mismatch <= 1'b1;
            r_armed  <= 1'b0;
            if (err_count != C_CNT_MAX)
              err_count <= err_count + CNT_W'(1);
          end
        end else begin
          r_armed <= 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sr_latch_monitor.sv
// +--------------------------------------------------------------------+
// | tb_sr_latch_monitor : directed self-checking bench                 |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_sr_latch_monitor;

  logic       clk = 1'b0;
  logic       clk_en = 1'b0;
  logic       rst_n = 1'b1;
  logic       S, R, Q, Qn;
  logic       pred_q, pred_valid, forbidden, mismatch;
  logic [7:0] err_count, forbid_count;

  int checks   = 0;
  int failures = 0;
  int exp_err;

  sr_latch_monitor #(.SETTLE_CYCLES(2), .CNT_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .S            (S),
    .R            (R),
    .Q            (Q),
    .Qn           (Qn),
    .pred_q       (pred_q),
    .pred_valid   (pred_valid),
    .forbidden    (forbidden),
    .mismatch     (mismatch),
    .err_count    (err_count),
    .forbid_count (forbid_count)
  );

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Returns just after the n-th rising edge from now.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    // 1. Async reset with no clock running
    {S, R, Q, Qn} = 4'($urandom);
    #2 rst_n = 1'b0;
    #1;
    check("rst_pred_q", pred_q, 0);
    check("rst_pred_valid", pred_valid, 0);
    check("rst_forbidden", forbidden, 0);
    check("rst_mismatch", mismatch, 0);
    check("rst_err_count", err_count, 0);
    check("rst_forbid_count", forbid_count, 0);
    S = 0; R = 0; Q = 1; Qn = 0;
    clk_en = 1'b1;
    cyc(3);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      check("idle_pred_valid", pred_valid, 0);
      check("idle_mismatch", mismatch, 0);
    end

    // 2. Correct set
    S = 1; Q = 1; Qn = 0;
    cyc(2);
    check("set_edge1_pred_valid", pred_valid, 0);
    cyc(1);
    check("set_pred_q", pred_q, 1);
    check("set_pred_valid", pred_valid, 1);
    for (int i = 0; i < 6; i++) begin
      cyc(1);
      check("set_mismatch", mismatch, 0);
    end
    S = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(1);
      check("hold_mismatch", mismatch, 0);
    end
    check("hold_pred_q", pred_q, 1);
    check("set_err_count", err_count, 0);

    // 3. Stuck fault: reset requested, Q stays high
    R = 1;
    for (int e = 0; e <= 4; e++) begin
      cyc(1);
      check("stuck_pre_mismatch", mismatch, 0);
      if (e == 2) begin
        check("stuck_pred_q", pred_q, 0);
        check("stuck_pred_valid", pred_valid, 1);
      end
    end
    cyc(1);
    check("stuck_pulse", mismatch, 1);
    check("stuck_err_count", err_count, 1);
    for (int i = 0; i < 30; i++) begin
      cyc(1);
      check("stuck_no_repeat", mismatch, 0);
    end
    check("stuck_err_hold", err_count, 1);

    // 4. Forbidden input, then release to unknown
    S = 1; R = 1; Q = 0; Qn = 0;
    cyc(3);
    check("forbid_flag", forbidden, 1);
    check("forbid_count", forbid_count, 1);
    check("forbid_pred_valid", pred_valid, 0);
    for (int i = 0; i < 8; i++) begin
      cyc(1);
      check("forbid_mismatch", mismatch, 0);
    end
    check("forbid_count_hold", forbid_count, 1);
    S = 0; R = 0; Q = 1; Qn = 0;
    cyc(3);
    check("unk_forbidden", forbidden, 0);
    check("unk_pred_valid", pred_valid, 0);
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      check("unk_mismatch", mismatch, 0);
    end
    check("unk_err_count", err_count, 1);

    // 5. Saturation: every R toggle re-arms a failing Q0 compare
    exp_err = 1;
    for (int i = 0; i < 300; i++) begin
      R = ~R;
      cyc(7);
      exp_err = (exp_err < 255) ? exp_err + 1 : 255;
      check("sat_err_count", err_count, exp_err);
    end
    check("sat_final", err_count, 255);

    // 6. Async reset while in FORBID
    S = 1; R = 1; Q = 0; Qn = 0;
    cyc(3);
    check("f2_forbidden", forbidden, 1);
    check("f2_forbid_count", forbid_count, 2);
    cyc(2);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_forbidden", forbidden, 0);
    check("mid_rst_forbid_count", forbid_count, 0);
    check("mid_rst_err_count", err_count, 0);
    check("mid_rst_pred_valid", pred_valid, 0);
    S = 0; R = 0; Q = 1; Qn = 0;
    cyc(2);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      check("post_rst_pred_valid", pred_valid, 0);
      check("post_rst_mismatch", mismatch, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
